bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//  - Sequential shift-add-3 (double-dabble) binary-to-BCD converter for the Binary-to-BCD display path.
//  - Converts one BIN_W-bit unsigned value per start request into NDIG packed BCD digits.
//  - Also produces a registered per-digit nonzero mask, digit_nz.
//  - digit_nz feeds the downstream 4-to-2 priority encoder, which finds the leading nonzero digit for leading-zero blanking.
// PARAMETERS
//  BIN_W   14   binary input width; 14 bits covers 0..9999.
//  NDIG    4    number of BCD output digits; must be 4 to match the downstream encoder.
// PORTS
//  clk       in   1        system clock, rising edge.
//  rst_n     in   1        asynchronous reset, active low.
//  start     in   1        conversion request; sampled only in IDLE.
//  bin_in    in   BIN_W    unsigned value; captured on the accepted start.
//  busy      out  1        high while a conversion is in progress (SHIFT and DONE).
//  done      out  1        one-cycle pulse; bcd_out, digit_nz and ovf are valid from this cycle.
//  bcd_out   out  4*NDIG   packed BCD; digit i occupies [4i+3:4i]; digit 0 is the units digit.
//  digit_nz  out  NDIG     digit_nz[i] = (digit i != 0); drives the encoder w input.
//  ovf       out  1        captured value exceeds 10^NDIG-1.
// BEHAVIOUR
//  - Reset (asynchronous, rst_n=0): every output is 0 (busy, done, bcd_out, digit_nz, ovf).
//    - The FSM goes to IDLE and the shift/counter registers clear.
//    - This applies immediately even mid-conversion; the partial result is discarded and done does not fire.
//  - FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE:
//    - start=1 captures bin_in into the shift register and clears the digit scratch.
//    - Sets cnt = BIN_W-1, computes ovf_next = (bin_in > 10^NDIG-1), and moves to SHIFT.
//    - start=0 stays in IDLE.
//  - SHIFT, one bit per cycle:
//    - Each scratch digit >= 5 gets +3 (combinational, all digits in parallel).
//    - The concatenation {scratch, shreg} is then shifted left by 1.
//    - The carry out of the top digit is dropped.
//    - When cnt == 0, go to DONE; otherwise cnt decrements.
//  - DONE, a single cycle:
//    - bcd_out and digit_nz are loaded from scratch; ovf is loaded.
//    - done=1, then return to IDLE.
//  - Latency: with start sampled at edge 0, done is high in the cycle after edge BIN_W+1 (BIN_W shift cycles plus 1).
//    - busy is high from edge 0 through the DONE cycle.
//  - Throughput: one conversion per BIN_W+2 cycles.
//    - The earliest re-accept is the IDLE cycle after DONE.
//  - start while busy (SHIFT or DONE) is ignored; it is neither queued nor able to corrupt the result.
//  - bcd_out, digit_nz and ovf hold their value until the next DONE or reset.
//  - Arithmetic: the scratch register is 4*NDIG bits and the counter is $clog2(BIN_W) bits.
//    - Without saturation, the result equals bin_in mod 10^NDIG.
//  - bin_in changing after acceptance has no effect.
// CONFIGURATION
//  BCD_SAT_EN defined:
//    - When ovf_next=1, DONE loads bcd_out with all digits = 9 (16'h9999 for NDIG=4) and digit_nz with all ones.
//    - ovf=1.
//  BCD_SAT_EN undefined:
//    - DONE loads the truncated result (value mod 10^NDIG) and its true digit_nz mask.
//    - ovf is still reported.
// STRUCTURE
//  - Package bin2bcd_pkg holds:
//    - the FSM state encoding (IDLE, SHIFT, DONE);
//    - BCD_DIG_W=4;
//    - MAX_BCD_VAL(NDIG) = 10^NDIG-1;
//    - the all-nines constant.
//  - Sub-module bcd_add3: a 4-bit combinational digit corrector (d>=5 ? d+3 : d).
//    - It is instantiated NDIG times via generate.
//  - Top level: FSM, counter, shift register and output registers.
// TESTING
//  1. bin_in=0, start -> done at cycle BIN_W+1, bcd_out=16'h0000, digit_nz=4'b0000, ovf=0.
//  2. bin_in=9999 -> bcd_out=16'h9999, digit_nz=4'b1111, ovf=0.
//  3. bin_in=1205 -> bcd_out=16'h1205, digit_nz=4'b1101; the encoder then gives y=2'b11, z=1.
//  4. bin_in=16383:
//     - with BCD_SAT_EN -> bcd_out=16'h9999, ovf=1;
//     - without it -> bcd_out=16'h6383, ovf=1.
//  5. bin_in=42, then start pulsed again with bin_in=77 during SHIFT cycle 5 and during DONE:
//     - exactly one done; bcd_out=16'h0042.
//  6. rst_n=0 for 1 cycle mid-SHIFT -> all outputs 0 immediately and no done pulse.
//     - A following start with 300 gives bcd_out=16'h0300 and digit_nz=4'b0100.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM encoding, digit width, range limit and the saturation pattern.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int BCD_DIG_W = 4;

    // Largest value representable in ndig BCD digits (10^ndig - 1).
    function automatic int unsigned MAX_BCD_VAL(input int ndig);
        int unsigned v;
        v = 1;
        for (int i = 0; i < ndig; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

    // Sliced to 4*NDIG bits where used.
    localparam logic [63:0] ALL_NINES = 64'h9999_9999_9999_9999;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a client and bin2bcd_seq.
// The master drives start/bin_in; the slave (converter) returns status and result.
interface bin2bcd_seq_if #(
    parameter int BIN_W = 14,
    parameter int NDIG  = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*NDIG-1:0]     bcd_out;
    logic [NDIG-1:0]       digit_nz;
    logic                  ovf;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, digit_nz, ovf
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, digit_nz, ovf
    );
endinterface

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Purpose: single BCD digit correction for double-dabble (d >= 5 ? d + 3 : d).
// Latency: combinational. Backpressure: none.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// Purpose: shift-add-3 binary-to-BCD converter with per-digit nonzero mask; BCD_SAT_EN clamps overflow to all nines.
// Latency: done the cycle after edge BIN_W+1 from accepted start. Backpressure: start ignored while busy, not queued.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W = 14,
    parameter int NDIG  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    bin2bcd_seq_if.slave bus
);
    localparam int          SCR_W   = BCD_DIG_W * NDIG;
    localparam int          CNT_W   = $clog2(BIN_W);
    localparam int unsigned MAX_VAL = MAX_BCD_VAL(NDIG);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIN_W-1:0]   shreg_q;
    logic [SCR_W-1:0]   scr_q;
    logic [SCR_W-1:0]   scr_adj;
    logic               ovf_pend_q;
    logic [SCR_W-1:0]   bcd_q;
    logic [NDIG-1:0]    nz_q;
    logic               ovf_q;
    logic               done_q;
    logic [SCR_W-1:0]   res_bcd;
    logic [NDIG-1:0]    res_nz;

    for (genvar g = 0; g < NDIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (scr_q[BCD_DIG_W*g +: BCD_DIG_W]),
            .q (scr_adj[BCD_DIG_W*g +: BCD_DIG_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        res_bcd = scr_q;
        res_nz  = '0;
        for (int i = 0; i < NDIG; i++) begin
            res_nz[i] = |scr_q[BCD_DIG_W*i +: BCD_DIG_W];
        end
`ifdef BCD_SAT_EN
        if (ovf_pend_q) begin
            res_bcd = ALL_NINES[SCR_W-1:0];
            res_nz  = '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            shreg_q    <= '0;
            scr_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            nz_q       <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        shreg_q    <= bus.bin_in;
                        scr_q      <= '0;
                        cnt_q      <= CNT_W'(BIN_W - 1);
                        ovf_pend_q <= (32'(bus.bin_in) > MAX_VAL);
                    end
                end
                ST_SHIFT: begin
                    // Top bit of the corrected scratch falls off: result is value mod 10^NDIG.
                    {scr_q, shreg_q} <= {scr_adj[SCR_W-2:0], shreg_q, 1'b0};
                    if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                end
                ST_DONE: begin
                    bcd_q  <= res_bcd;
                    nz_q   <= res_nz;
                    ovf_q  <= ovf_pend_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.digit_nz = nz_q;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed-vector bench for bin2bcd_seq; expected values are hand-computed constants.
// Optional BCD_SAT_EN changes the expected result for the out-of-range vector.
module tb_bin2bcd_seq;
    localparam int BIN_W = 14;
    localparam int NDIG  = 4;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    bin2bcd_seq_if #(.BIN_W(BIN_W), .NDIG(NDIG)) bus ();

    bin2bcd_seq #(.BIN_W(BIN_W), .NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accepts val at the next edge, then watches done; optionally pokes start
    // (with a different bin_in) during SHIFT cycle 5 and during DONE.
    task automatic run(input string tag, input logic [BIN_W-1:0] val,
                       input logic [15:0] exp_bcd, input logic [3:0] exp_nz,
                       input logic exp_ovf, input bit poke);
        int done_cyc;
        int n_done;
        done_cyc = -1;
        n_done   = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = val;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == 0) check({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
            if (poke) begin
                bus.start  = (cyc == 4) || (cyc == BIN_W);
                bus.bin_in = (cyc >= 4) ? 14'd77 : val;
            end
            if (done_cyc >= 0 && cyc == done_cyc) begin
                check({tag, " bcd_out"},  32'(bus.bcd_out),  32'(exp_bcd));
                check({tag, " digit_nz"}, 32'(bus.digit_nz), 32'(exp_nz));
                check({tag, " ovf"},      32'(bus.ovf),      32'(exp_ovf));
                check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check({tag, " done_width"}, 32'(bus.done), 32'd0);
                check({tag, " hold_bcd"},   32'(bus.bcd_out), 32'(exp_bcd));
            end
            if (!poke && done_cyc >= 0 && cyc > done_cyc + 1) break;
            @(posedge clk);
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (done_cyc < 0) check({tag, " timeout"}, 32'd0, 32'd1);
        else              check({tag, " latency"}, 32'(done_cyc), 32'(BIN_W + 1));
        check({tag, " done_count"}, 32'(n_done), 32'd1);
    endtask

    initial begin
        int n_done;
        n_chk      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        #12;
        check("reset busy",     32'(bus.busy),     32'd0);
        check("reset done",     32'(bus.done),     32'd0);
        check("reset bcd_out",  32'(bus.bcd_out),  32'd0);
        check("reset digit_nz", 32'(bus.digit_nz), 32'd0);
        check("reset ovf",      32'(bus.ovf),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("v0",    14'd0,     16'h0000, 4'b0000, 1'b0, 1'b0);
        run("v9999", 14'd9999,  16'h9999, 4'b1111, 1'b0, 1'b0);
        run("v1205", 14'd1205,  16'h1205, 4'b1101, 1'b0, 1'b0);
`ifdef BCD_SAT_EN
        run("v16383", 14'd16383, 16'h9999, 4'b1111, 1'b1, 1'b0);
`else
        run("v16383", 14'd16383, 16'h6383, 4'b1111, 1'b1, 1'b0);
`endif
        run("v42_poke", 14'd42, 16'h0042, 4'b0011, 1'b0, 1'b1);

        // Reset in the middle of a conversion.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 14'd5555;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst busy",     32'(bus.busy),     32'd0);
        check("mid_rst done",     32'(bus.done),     32'd0);
        check("mid_rst bcd_out",  32'(bus.bcd_out),  32'd0);
        check("mid_rst digit_nz", 32'(bus.digit_nz), 32'd0);
        check("mid_rst ovf",      32'(bus.ovf),      32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("mid_rst no_done", 32'(n_done), 32'd0);
        check("mid_rst idle", 32'(bus.busy), 32'd0);

        run("v300", 14'd300, 16'h0300, 4'b0100, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
